// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES carry-chained slices, one slice per cycle,
// valid/ready handshake with a global stall, carry-out and signed-overflow flags.
`timescale 1ns/1ps
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SLICE = (STAGES > 0) ? WIDTH / STAGES : WIDTH;
  localparam int LAST  = (STAGES > 0) ? STAGES - 1 : 0;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be >= 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_adder: STAGES must divide WIDTH evenly");
  end

  function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{SLICE{1'b0}}, ci};
  endfunction

  logic             stall;
  logic             vld_p [STAGES];
  // Operand skew (opa_p/opb_p), deskewed partial result (res_p) and slice carry (cry_p)
  logic [WIDTH-1:0] opa_p [STAGES];
  logic [WIDTH-1:0] opb_p [STAGES];
  logic [WIDTH-1:0] res_p [STAGES];
  logic             cry_p [STAGES];

  logic [WIDTH-1:0] sin_a [STAGES];
  logic [WIDTH-1:0] sin_b [STAGES];
  logic [WIDTH-1:0] sin_r [STAGES];
  logic             sin_c [STAGES];
  logic [WIDTH-1:0] nxt_r [STAGES];
  logic             nxt_c [STAGES];
  logic [SLICE:0]   slc   [STAGES];
  logic             msb_cin;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_p[LAST];

  always_comb begin
    // Stage 0 takes the ports; subtraction is A + ~B + 1 with the +1 as carry-in
    sin_a[0] = a;
    sin_b[0] = sub ? ~b : b;
    sin_c[0] = sub;
    sin_r[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      sin_a[k] = opa_p[k-1];
      sin_b[k] = opb_p[k-1];
      sin_c[k] = cry_p[k-1];
      sin_r[k] = res_p[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slc[k]   = slice_add(sin_a[k][k*SLICE +: SLICE], sin_b[k][k*SLICE +: SLICE], sin_c[k]);
      nxt_r[k] = sin_r[k];
      nxt_r[k][k*SLICE +: SLICE] = slc[k][SLICE-1:0];
      nxt_c[k] = slc[k][SLICE];
    end
    // Carry into the MSB recovered from the MSB's own sum bit
    msb_cin = sin_a[LAST][WIDTH-1] ^ sin_b[LAST][WIDTH-1] ^ nxt_r[LAST][WIDTH-1];
  end

  // ---- stage registers: control and output stage (reset) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= in_valid & in_ready;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      sum      <= nxt_r[LAST];
      cout     <= nxt_c[LAST];
      overflow <= msb_cin ^ nxt_c[LAST];
    end
  end

  // ---- stage registers: intermediate datapath (no reset) ----
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int k = 0; k < LAST; k++) begin
        opa_p[k] <= sin_a[k];
        opb_p[k] <= sin_b[k];
        res_p[k] <= nxt_r[k];
        cry_p[k] <= nxt_c[k];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three configurations (32/4, 16/1, 64/8) run in parallel.
`timescale 1ns/1ps
module tb_pipelined_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit done [3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.cyc = 0;
    return e;
  endfunction

  // Reference: plain wide arithmetic and sign rules, modulo 2^w
  function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                 input logic s);
    logic [63:0] mask, xm, yb;
    logic [64:0] full;
    exp_t        e;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    xm    = x & mask;
    yb    = s ? (~y & mask) : (y & mask);
    full  = {1'b0, xm} + {1'b0, yb} + {64'd0, s};
    e.sum  = full[63:0] & mask;
    e.cout = full[w];
    e.ovf  = (xm[w-1] == yb[w-1]) && (e.sum[w-1] != xm[w-1]);
    e.cyc  = 0;
    return e;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 32 : (gi == 1) ? 16 : 64;
    localparam int S = (gi == 0) ? 4  : (gi == 1) ? 1  : 8;

    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         sub       = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;

    exp_t         q [$];
    exp_t         m_e;
    bit           lat_chk    = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_c, prev_o;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(ovf)
    );

    function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0:       return '1;
        1:       return {1'b0, {(W-1){1'b1}}};
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return W'(1);
        default: return r[W-1:0];
      endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input exp_t e, input bit bp);
      bit ok = 1'b0;
      a = x; b = y; sub = s; in_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (in_ready) begin
          e.cyc = cyc;
          q.push_back(e);
          ok = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!ok) begin
        n_chk++; n_fail++;
        $display("FAIL cfg%0d accept: in_ready stuck low, required 1 within 200 cycles", gi);
      end
    endtask

    task automatic drain();
      int t = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (q.size() > 0 && t < 500) begin
        @(posedge clk); #1;
        t++;
      end
      if (q.size() > 0) begin
        n_chk++; n_fail++;
        $display("FAIL cfg%0d drain: %0d results pending, required 0", gi, q.size());
      end
    endtask

    initial begin : stim
      logic [W-1:0] x, y;
      logic         s;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("cfg%0d rst out_valid", gi), 64'(out_valid), 64'd0);
      chk($sformatf("cfg%0d rst sum", gi), 64'(sum), 64'd0);
      chk($sformatf("cfg%0d rst cout", gi), 64'(cout), 64'd0);
      chk($sformatf("cfg%0d rst overflow", gi), 64'(ovf), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("cfg%0d in_ready after reset", gi), 64'(in_ready), 64'd1);

      lat_chk = 1'b1;
      if (gi == 0) begin
        issue(W'(32'h0000FFFF), W'(32'h00000001), 1'b0, mk(64'h00010000, 1'b0, 1'b0), 1'b0);
        issue(W'(32'hFFFFFFFF), W'(32'h00000001), 1'b0, mk(64'h00000000, 1'b1, 1'b0), 1'b0);
        issue(W'(32'h7FFFFFFF), W'(32'h00000001), 1'b0, mk(64'h80000000, 1'b0, 1'b1), 1'b0);
        issue(W'(32'h00000005), W'(32'h00000007), 1'b1, mk(64'hFFFFFFFE, 1'b0, 1'b0), 1'b0);
        issue(W'(32'h80000000), W'(32'h00000001), 1'b1, mk(64'h7FFFFFFF, 1'b1, 1'b1), 1'b0);
      end
      repeat (30) begin
        x = rnd(); y = rnd(); s = 1'($urandom_range(0, 1));
        issue(x, y, s, model(W, 64'(x), 64'(y), s), 1'b0);
      end
      drain();

      // Backpressure phase: random out_ready and occasional input gaps
      lat_chk = 1'b0;
      repeat (60) begin
        x = rnd(); y = rnd(); s = 1'($urandom_range(0, 1));
        issue(x, y, s, model(W, 64'(x), 64'(y), s), 1'b1);
        if ($urandom_range(0, 3) == 0) begin
          in_valid  = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      drain();

      // Reset while operations are in flight
      repeat (3) begin
        x = rnd(); y = rnd(); s = 1'($urandom_range(0, 1));
        issue(x, y, s, model(W, 64'(x), 64'(y), s), 1'b0);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk($sformatf("cfg%0d midrst out_valid", gi), 64'(out_valid), 64'd0);
      chk($sformatf("cfg%0d midrst sum", gi), 64'(sum), 64'd0);
      chk($sformatf("cfg%0d midrst cout", gi), 64'(cout), 64'd0);
      chk($sformatf("cfg%0d midrst overflow", gi), 64'(ovf), 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("cfg%0d in_ready after midrst", gi), 64'(in_ready), 64'd1);
      chk($sformatf("cfg%0d out_valid after midrst", gi), 64'(out_valid), 64'd0);
      repeat (S + 3) @(posedge clk);
      #1;

      lat_chk = 1'b1;
      repeat (5) begin
        x = rnd(); y = rnd(); s = 1'($urandom_range(0, 1));
        issue(x, y, s, model(W, 64'(x), 64'(y), s), 1'b0);
      end
      drain();
      done[gi] = 1'b1;
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk($sformatf("cfg%0d in_ready", gi), 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          chk($sformatf("cfg%0d stall out_valid", gi), 64'(out_valid), 64'd1);
          chk($sformatf("cfg%0d stall sum", gi), 64'(sum), 64'(prev_sum));
          chk($sformatf("cfg%0d stall flags", gi), {62'd0, cout, ovf}, {62'd0, prev_c, prev_o});
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL cfg%0d unexpected result: got sum %0h, required no output", gi, sum);
          end else begin
            m_e = q.pop_front();
            chk($sformatf("cfg%0d sum", gi), 64'(sum), m_e.sum);
            chk($sformatf("cfg%0d cout", gi), 64'(cout), 64'(m_e.cout));
            chk($sformatf("cfg%0d overflow", gi), 64'(ovf), 64'(m_e.ovf));
            if (lat_chk)
              chk($sformatf("cfg%0d latency", gi), 64'(cyc - m_e.cyc), 64'(S));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_c     = cout;
        prev_o     = ovf;
      end
    end
  end

  initial begin : top
    for (int t = 0; t < 40000; t++) begin
      @(posedge clk);
      if (done[0] && done[1] && done[2]) break;
    end
    if (!(done[0] && done[1] && done[2])) begin
      n_chk++; n_fail++;
      $display("FAIL global timeout: done=%0b%0b%0b, required 111", done[2], done[1], done[0]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the datapath's single-cycle 32-bit adder.
- Splits a WIDTH-bit add or subtract into STAGES carry-chained slices, one slice per cycle, to shorten the critical path.
- Accepts one operation per cycle under a valid/ready handshake and produces carry-out and signed-overflow flags.
- Sits between the register-read stage and writeback in the core datapath.

Parameters:
- WIDTH, 32, operand and result width in bits.
- STAGES, 4, number of pipeline stages. Must be >= 1 and must divide WIDTH evenly.
- SLICE, WIDTH/STAGES, derived value (not overridable): bits added per stage.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- In_Valid  input  1  operation present on A, B, Sub.
- In_Ready  output  1  block accepts the operation this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0 = A+B; 1 = A-B.
- Out_Valid  output  1  result valid on Sum, Cout, Overflow.
- Out_Ready  input  1  downstream accepts the result.
- Sum  output  WIDTH  result, modulo 2^WIDTH.
- Cout  output  1  carry out of MSB (for Sub=1: 1 means no borrow).
- Overflow  output  1  two's-complement signed overflow.

Behaviour:
- Interface decision: one clock (Clk); reset Rst_n is asynchronous and active-low. Reset asserts immediately on Rst_n=0; deassertion is sampled on the Clk edge.
- Reset values:
  - All stage valid bits, Out_Valid, Sum, Cout and Overflow are 0.
  - In_Ready = 1 once reset is released.
- Transfer rules:
  - Input transfer: In_Valid & In_Ready at a rising edge.
  - Output transfer: Out_Valid & Out_Ready at a rising edge.
- Stall:
  - stall = Out_Valid & ~Out_Ready.
  - In_Ready = ~stall, driven combinationally. No dependency on In_Valid.
  - While stall=1, every stage register, including the outputs, holds its value. Sum, Cout and Overflow remain stable until accepted.
- Advance:
  - When stall=0, all stages shift one step each cycle.
  - Stage 0 valid loads In_Valid & In_Ready.
  - Bubbles shift like data. There is no bubble collapsing.
- Latency and throughput:
  - Latency is exactly STAGES cycles from input transfer to Out_Valid=1, with no stall.
  - Throughput is 1 operation per cycle with Out_Ready held at 1.
- Arithmetic:
  - Effective B' = Sub ? ~B : B. Carry-in to slice 0 = Sub.
  - Stage k adds bits [k*SLICE +: SLICE] of A and B' plus the carry registered from stage k-1.
  - Not-yet-consumed upper operand slices travel with the operation (operand skew registers).
  - Completed lower result slices are carried forward (deskew registers), so all WIDTH bits of Sum appear together at the output.
  - Cout = carry out of bit WIDTH-1.
  - Overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered in the final stage.
- Degenerate case: STAGES=1 gives a single registered adder with latency 1 and the same handshake.
- Wrap-around: results wrap modulo 2^WIDTH with no saturation. Flags report the condition only.
- Simultaneous events:
  - Out_Valid=1, Out_Ready=1 and In_Valid=1 in the same cycle: the output is consumed, the pipeline advances and the new input is accepted in that same cycle.
  - Back-to-back operations retain order. Nothing is dropped or duplicated.
- Reset mid-operation: all in-flight operations are discarded and Out_Valid drops to 0 asynchronously. No result of a pre-reset operation ever appears.
- X-safety: stage data registers need not be reset. Valid bits, outputs and flags must be reset.
- Elaboration: a STAGES or WIDTH combination that violates the divisibility rule is an elaboration error.

Test Plan:
- Reset: hold Rst_n=0 mid-stream, then release -> Out_Valid=0, Sum=0, Cout=0, Overflow=0; In_Ready=1 after release; no stale result emerges.
- Add latency (defaults): Out_Ready=1; A=0x0000FFFF, B=0x00000001, Sub=0 at cycle 0 -> cycle 4: Out_Valid=1, Sum=0x00010000, Cout=0, Overflow=0.
- Full carry ripple across all slices: A=0xFFFFFFFF, B=0x00000001, Sub=0 -> Sum=0x00000000, Cout=1, Overflow=0.
- Subtract and signed overflow:
  - A=0x7FFFFFFF, B=0x00000001, Sub=0 -> Sum=0x80000000, Overflow=1, Cout=0.
  - A=0x00000005, B=0x00000007, Sub=1 -> Sum=0xFFFFFFFE, Cout=0, Overflow=0.
- Backpressure: stream 8 random operations back-to-back while toggling Out_Ready at random -> results are in order and match the A±B model; outputs are stable while stalled; In_Ready=0 exactly when Out_Valid & ~Out_Ready.
- Parametrisation: rerun the above with (WIDTH=16, STAGES=1) and (WIDTH=64, STAGES=8) -> latency equals STAGES; results match the modulo-2^WIDTH model.
